// File: rtl/fir_filter.sv
// 15-tap direct-form fixed-point FIR filter. Each tap product is floored to
// its own fractional width, the products are aligned and summed, and the sum
// is floored to the output format and saturated.
// Pipeline: delay line (E0) -> tap products (E1) -> saturated sum (E2).

// One tap: full-precision product, floored to PF fractional bits, then
// left-aligned to PFMAX fractional bits so all taps sum on a common grid.
module fir_tap #(
  parameter int CW    = 12,
  parameter int IW    = 12,
  parameter int FFULL = 16,  // fractional bits of the full product
  parameter int PF    = 12,  // fractional bits kept for this tap
  parameter int PFMAX = 12,  // common alignment grid
  parameter int PW    = 20,  // aligned product width
  parameter int COEF  = 1
) (
  input  logic signed [IW-1:0] x,
  output logic signed [PW-1:0] p
);
  localparam int FW    = CW + IW;
  localparam int DROP  = FFULL - PF;
  localparam int ALIGN = PFMAX - PF;
  localparam logic signed [CW-1:0] C = CW'(COEF);

  logic signed [FW-1:0] full;

  assign full = FW'(x) * FW'(C);
  // arithmetic shift right floors toward -inf; the kept value always fits PW
  assign p    = PW'(full >>> DROP) <<< ALIGN;
endmodule

module fir_filter #(
  parameter int COE_INTE_WL = 4,
  parameter int COE_FRAC_WL = 8,
  parameter int IN_INTE_WL  = 4,
  parameter int IN_FRAC_WL  = 8,
  parameter int OUT_INTE_WL = 4,
  parameter int OUT_FRAC_WL = 8,
  parameter int PRODUCT_FRAC_WL_ARRAY [0:14] =
    '{12, 12, 12, 12, 12, 12, 12, 12, 12, 12, 12, 12, 12, 12, 12},
  parameter int COEFFS [0:14] =
    '{1, 2, 4, 8, 12, 16, 20, 24, 20, 16, 12, 8, 4, 2, 1}
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic signed [IN_INTE_WL+IN_FRAC_WL-1:0]   data_in,
  input  logic                                     in_valid,
  output logic signed [OUT_INTE_WL+OUT_FRAC_WL-1:0] data_out,
  output logic                                     out_valid
);
  localparam int NTAPS  = 15;
  localparam int STAGES = 3;
  localparam int CW     = COE_INTE_WL + COE_FRAC_WL;
  localparam int IW     = IN_INTE_WL + IN_FRAC_WL;
  localparam int OW     = OUT_INTE_WL + OUT_FRAC_WL;
  localparam int PINT   = COE_INTE_WL + IN_INTE_WL;
  localparam int FFULL  = COE_FRAC_WL + IN_FRAC_WL;

  function automatic int pf_max();
    int m = 0;
    for (int k = 0; k < NTAPS; k++)
      if (PRODUCT_FRAC_WL_ARRAY[k] > m) m = PRODUCT_FRAC_WL_ARRAY[k];
    return m;
  endfunction

  localparam int PFMAX = pf_max();
  localparam int PW    = PINT + PFMAX;      // aligned product width
  localparam int AW    = PINT + 4 + PFMAX;  // 16 > 15 taps: sum cannot overflow
  localparam logic signed [AW-1:0] OMAX = AW'((2 ** (OW - 1)) - 1);
  localparam logic signed [AW-1:0] OMIN = AW'(-(2 ** (OW - 1)));

  logic [NTAPS-1:0][IW-1:0] dl;       // dl[0] is the newest sample
  logic [NTAPS-1:0][PW-1:0] prod_c;
  logic [NTAPS-1:0][PW-1:0] prod_q;
  logic [STAGES-1:0]        vld_pipe; // vld_pipe[STAGES-1] is out_valid
  logic signed [AW-1:0]     acc;
  logic signed [AW-1:0]     fl;
  logic signed [OW-1:0]     sat;

  // Delay line shifts only on accepted samples
  always_ff @(posedge clk or negedge rst)
    if (!rst)          dl <= '0;
    else if (in_valid) dl <= {dl[NTAPS-2:0], data_in};

  genvar k;
  generate
    for (k = 0; k < NTAPS; k++) begin : g_tap
      logic signed [PW-1:0] p;
      fir_tap #(
        .CW(CW), .IW(IW), .FFULL(FFULL), .PF(PRODUCT_FRAC_WL_ARRAY[k]),
        .PFMAX(PFMAX), .PW(PW), .COEF(COEFFS[k])
      ) u_tap (
        .x(dl[k]),
        .p(p)
      );
      assign prod_c[k] = p;
    end
  endgenerate

  // Product stage register; recomputed every cycle, qualified by vld_pipe
  always_ff @(posedge clk or negedge rst)
    if (!rst) prod_q <= '0;
    else      prod_q <= prod_c;

  // Sum aligned products, floor to the output grid, then clamp
  always_comb begin
    acc = '0;
    for (int i = 0; i < NTAPS; i++) acc = acc + AW'($signed(prod_q[i]));
    fl  = acc >>> (PFMAX - OUT_FRAC_WL);
    if (fl > OMAX)      sat = OW'(OMAX);
    else if (fl < OMIN) sat = OW'(OMIN);
    else                sat = fl[OW-1:0];
  end

  // Valid flags travel with the data, one bit per stage
  always_ff @(posedge clk or negedge rst)
    if (!rst) vld_pipe <= '0;
    else      vld_pipe <= {vld_pipe[STAGES-2:0], in_valid};

  // Output register holds its value between valid results
  always_ff @(posedge clk or negedge rst)
    if (!rst)                    data_out <= '0;
    else if (vld_pipe[STAGES-2]) data_out <= sat;

  assign out_valid = vld_pipe[STAGES-1];
endmodule

// File: tb/tb_fir_filter.sv
// Scoreboard bench for fir_filter: tasks push expected outputs as samples are
// driven; a negedge monitor pops and compares whenever out_valid is high.
module tb_fir_filter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic signed [11:0] din = '0;
  logic va = 1'b0;
  logic vb = 1'b0;
  logic signed [11:0] doa, dob;
  logic ova, ovb;

  int checks = 0;
  int failures = 0;
  int qa[$];
  int qb[$];

  int imp_exp [16] = '{1, 2, 4, 8, 12, 16, 20, 24, 20, 16, 12, 8, 4, 2, 1, 0};
  int cum_exp [15] = '{1, 3, 7, 15, 27, 43, 63, 87, 107, 123, 135, 143, 147, 149, 150};

  always #5 clk = ~clk;

  fir_filter dut_a (
    .clk(clk), .rst(rst), .data_in(din), .in_valid(va),
    .data_out(doa), .out_valid(ova)
  );

  fir_filter #(
    .COEFFS('{256, 256, 256, 256, 256, 256, 256, 256, 256, 256, 256, 256, 256, 256, 256})
  ) dut_b (
    .clk(clk), .rst(rst), .data_in(din), .in_valid(vb),
    .data_out(dob), .out_valid(ovb)
  );

  // Scoreboard monitors
  always @(negedge clk) begin
    if (ova) begin
      checks++;
      if (qa.size() == 0) begin
        failures++;
        $display("FAIL sb_a_unexpected: got data_out=%0d with no expected value", doa);
      end else begin
        int e;
        e = qa.pop_front();
        if (doa !== e) begin
          failures++;
          $display("FAIL sb_a_data: got %0d expected %0d", doa, e);
        end
      end
    end
    if (ovb) begin
      checks++;
      if (qb.size() == 0) begin
        failures++;
        $display("FAIL sb_b_unexpected: got data_out=%0d with no expected value", dob);
      end else begin
        int e;
        e = qb.pop_front();
        if (dob !== e) begin
          failures++;
          $display("FAIL sb_b_data: got %0d expected %0d", dob, e);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    cyc();
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20; i++) begin
      if (qa.size() == 0 && qb.size() == 0) break;
      cyc();
    end
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: pending a=%0d b=%0d expected 0", name, qa.size(), qb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; va = 1'b1; din = 12'sd256;
    repeat (3) cyc();
    checks++;
    if (doa !== 12'sd0 || ova !== 1'b0 || dob !== 12'sd0 || ovb !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got a=%0d/%b b=%0d/%b expected 0/0", doa, ova, dob, ovb);
    end
    va = 1'b0; din = '0;
    @(negedge clk);
    rst = 1'b1;
    cyc();
    checks++;
    if (ova !== 1'b0 || doa !== 12'sd0) begin
      failures++;
      $display("FAIL reset_release: got %0d/%b expected 0/0", doa, ova);
    end
  endtask

  task automatic test_impulse(input string name);
    for (int i = 0; i < 16; i++) begin
      va = 1'b1;
      din = (i == 0) ? 12'sd256 : 12'sd0;
      qa.push_back(imp_exp[i]);
      cyc();
      if (i < 4) begin
        logic e;
        e = (i >= 2);
        checks++;
        if (ova !== e) begin
          failures++;
          $display("FAIL %s_latency: edge %0d got out_valid=%b expected %b", name, i, ova, e);
        end
      end
    end
    va = 1'b0;
    drain(name);
  endtask

  task automatic test_step();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      va = 1'b1; din = 12'sd256;
      qa.push_back(i < 15 ? cum_exp[i] : 150);
      cyc();
    end
    va = 1'b0;
    drain("step");
  endtask

  task automatic test_lsb();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      va = 1'b1;
      din = (i == 0) ? -12'sd1 : 12'sd0;
      qa.push_back(i < 15 ? -1 : 0);
      cyc();
    end
    va = 1'b0;
    drain("lsb_neg");
    do_reset();
    for (int i = 0; i < 16; i++) begin
      va = 1'b1;
      din = (i == 0) ? 12'sd1 : 12'sd0;
      qa.push_back(0);
      cyc();
    end
    va = 1'b0;
    drain("lsb_pos");
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      vb = 1'b1; din = 12'sd2047;
      qb.push_back(2047);
      cyc();
    end
    vb = 1'b0;
    drain("sat_pos");
    do_reset();
    for (int i = 0; i < 20; i++) begin
      vb = 1'b1; din = -12'sd2048;
      qb.push_back(-2048);
      cyc();
    end
    vb = 1'b0;
    drain("sat_neg");
  endtask

  task automatic test_valid_gaps();
    logic pat [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    do_reset();
    qa.push_back(1); qa.push_back(2); qa.push_back(4);
    for (int i = 0; i < 7; i++) begin
      va  = (i < 5) ? pat[i] : 1'b0;
      din = (i == 0) ? 12'sd256 : 12'sd0;
      cyc();
      if (i >= 2) begin
        checks++;
        if (ova !== pat[i-2]) begin
          failures++;
          $display("FAIL gaps_valid: slot %0d got %b expected %b", i - 2, ova, pat[i-2]);
        end
        if (!pat[i-2]) begin
          checks++;
          if (doa !== 12'sd2) begin
            failures++;
            $display("FAIL gaps_hold: slot %0d got %0d expected 2", i - 2, doa);
          end
        end
      end
    end
    va = 1'b0;
    drain("gaps");
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      va = 1'b1;
      din = (i == 0) ? 12'sd256 : 12'sd77;
      if (i < 3) qa.push_back(imp_exp[i]);
      cyc();
    end
    // rst drops mid-cycle with samples still in flight
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if (doa !== 12'sd0 || ova !== 1'b0) begin
      failures++;
      $display("FAIL midrst_async: got %0d/%b expected 0/0", doa, ova);
    end
    qa.delete();
    cyc();
    checks++;
    if (doa !== 12'sd0 || ova !== 1'b0) begin
      failures++;
      $display("FAIL midrst_held: got %0d/%b expected 0/0", doa, ova);
    end
    va = 1'b0; din = '0;
    @(negedge clk);
    rst = 1'b1;
    cyc();
    test_impulse("post_reset");
  endtask

  initial begin
    test_reset();
    test_impulse("impulse");
    test_step();
    test_lsb();
    test_saturation();
    test_valid_gaps();
    test_reset_mid();
    repeat (4) cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
